uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter.
//
// Bytes written through a valid/ready handshake are queued in a small
// synchronous FIFO and serialized LSB-first onto tx: one start bit (0),
// eight data bits, one stop bit (1), each CLKS_PER_BIT clocks long.
// When more data is queued, the next start bit follows the stop bit
// directly, with no idle cycle in between.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   in_data    byte to transmit
//   in_valid   in_data is presented for write
//   in_ready   FIFO has room (fifo_count != FIFO_DEPTH)
//   tx         registered serial output, idle high
//   busy       a frame is in progress or bytes are queued
//   fifo_count bytes queued, excluding the byte being shifted out
module uart_tx #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BAUD_RATE    = 1_000_000,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_tx;
    logic [CW-1:0]   r_clk_count;
    logic [2:0]      r_bit_index;
    logic [7:0]      r_shift;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [NW-1:0]   r_count;
    logic [7:0]      r_mem [FIFO_DEPTH];

    state_t          w_state_next;
    logic            w_tx_next;
    logic [CW-1:0]   w_clk_count_next;
    logic [2:0]      w_bit_index_next;
    logic [7:0]      w_shift_next;
    logic [NW-1:0]   w_count_next;
    logic            w_wr;
    logic            w_pop;
    logic            w_bit_end;
    logic [7:0]      w_head;

    assign in_ready   = (r_count != FULL_CNT);
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

    assign w_wr      = in_valid && in_ready;
    assign w_bit_end = (r_clk_count == LAST_CLK);
    assign w_head    = r_mem[r_rd_ptr];

    // FIFO storage: no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_tx_next        = r_tx;
        w_clk_count_next = r_clk_count;
        w_bit_index_next = r_bit_index;
        w_shift_next     = r_shift;
        w_pop            = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_next        = 1'b1;
                w_clk_count_next = '0;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_count_next = '0;
                    w_tx_next        = r_shift[0];
                    w_bit_index_next = 3'd0;
                    w_state_next     = S_DATA;
                end else begin
                    w_clk_count_next = r_clk_count + CW'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_count_next = '0;
                    w_shift_next     = {1'b0, r_shift[7:1]};
                    if (r_bit_index == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        // r_shift[1] becomes bit 0 after this shift.
                        w_tx_next        = r_shift[1];
                        w_bit_index_next = r_bit_index + 3'd1;
                    end
                end else begin
                    w_clk_count_next = r_clk_count + CW'(1);
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_count_next = '0;
                    if (r_count != '0) begin
                        // Back-to-back frame: straight into the next start bit.
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_tx_next    = 1'b0;
                        w_state_next = S_START;
                    end else begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_clk_count_next = r_clk_count + CW'(1);
                end
            end
            default: begin
                w_tx_next        = 1'b1;
                w_clk_count_next = '0;
                w_state_next     = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + NW'(1);
            2'b01:   w_count_next = r_count - NW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tx        <= 1'b1;
            r_clk_count <= '0;
            r_bit_index <= '0;
            r_shift     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_tx        <= w_tx_next;
            r_clk_count <= w_clk_count_next;
            r_bit_index <= w_bit_index_next;
            r_shift     <= w_shift_next;
            r_count     <= w_count_next;
            // Pointers wrap naturally since FIFO_DEPTH is a power of two.
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx.
//
// The reference model works at frame level: a queue of pending bytes and
// the start cycle of the frame currently on the line.  Expected tx is the
// bit of the 10-bit frame selected by (cycles since start) / CLKS_PER_BIT.
// A separate serial receiver decodes tx and its byte stream is compared
// against the bytes the model put on the line.
module tb_uart_tx;

    localparam int CPB   = 10;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;

    uart_tx #(
        .CLK_FREQ   (10_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    bit         m_active = 1'b0;
    int         m_start = 0;
    logic [9:0] m_frame = 10'h3FF;
    int         cyc = 0;

    task automatic model_edge(input logic v, input logic [7:0] d, output bit acc);
        int pre;
        logic [7:0] b;
        pre = m_q.size();
        cyc++;
        acc = v && (pre < DEPTH);
        if ((!m_active || cyc == m_start + FRAME) && pre != 0) begin
            b = m_q.pop_front();
            m_frame  = {1'b1, b, 1'b0};
            m_start  = cyc;
            m_active = 1'b1;
            m_sent.push_back(b);
        end else if (m_active && cyc == m_start + FRAME) begin
            m_active = 1'b0;
        end
        if (acc) begin
            m_q.push_back(d);
            $display("push %02h at cycle %0d, queued %0d", d, cyc, m_q.size());
        end
    endtask

    task automatic model_reset();
        if (m_active && (cyc - m_start) < 9 * CPB + CPB / 2) begin
            void'(m_sent.pop_back());
        end
        m_q.delete();
        m_active = 1'b0;
    endtask

    task automatic check_all();
        logic e_tx;
        int   idx;
        if (m_active) begin
            idx  = (cyc - m_start) / CPB;
            e_tx = m_frame[idx];
        end else begin
            e_tx = 1'b1;
        end
        check("tx", {31'd0, tx}, {31'd0, e_tx});
        check("fifo_count", {28'd0, fifo_count}, m_q.size());
        check("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() != DEPTH});
        check("busy", {31'd0, busy}, {31'd0, m_active || m_q.size() != 0});
    endtask

    // One clock: drive inputs, let the edge happen, check at the falling edge.
    task automatic step(input logic v, input logic [7:0] d, output bit acc);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(v, d, acc);
        @(negedge clk);
        in_valid = 1'b0;
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 2000) begin
            step(1'b1, d, acc);
            n++;
        end
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc);
    endtask

    task automatic wait_idle();
        bit acc;
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < 3000) begin
            step(1'b0, 8'h00, acc);
            n++;
        end
    endtask

    // ---------------- serial receiver on tx ----------------
    logic [7:0] rx_q[$];
    int         rx_stop_err = 0;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_shift = 8'h00;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= tx;
            if (!rx_busy) begin
                if (rx_prev && !tx) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= 1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt >= CPB && rx_cnt % CPB == CPB / 2 && rx_cnt < 9 * CPB) begin
                    rx_shift <= {tx, rx_shift[7:1]};
                end
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    if (tx !== 1'b1) rx_stop_err <= rx_stop_err + 1;
                    rx_q.push_back(rx_shift);
                    rx_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit         acc;
        bit         pending;
        logic [7:0] pdata;
        int         n;
        int         pct[4];

        pct[0] = 2; pct[1] = 5; pct[2] = 20; pct[3] = 60;

        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // single 0x55 from idle
        send_byte(8'h55);
        wait_idle();
        idle(5);

        // three frames back to back
        send_byte(8'hA3);
        send_byte(8'h00);
        send_byte(8'hFF);
        wait_idle();
        idle(5);

        // ten consecutive write attempts against an 8-deep FIFO
        for (int i = 0; i < 10; i++) step(1'b1, 8'h30 + 8'(i), acc);
        wait_idle();
        idle(3);

        // random producer, rates from sparse to saturating
        pending = 1'b0;
        pdata   = 8'h00;
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                if (!pending && $urandom_range(0, 99) < pct[ph]) begin
                    pending = 1'b1;
                    pdata   = 8'($urandom_range(0, 255));
                end
                step(pending, pdata, acc);
                if (acc) pending = 1'b0;
            end
        end
        while (pending) begin
            step(1'b1, pdata, acc);
            if (acc) pending = 1'b0;
        end
        wait_idle();
        idle(3);

        // reset in the middle of the data bits with bytes still queued
        send_byte(8'h0F);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        n = 0;
        while (!(m_active && (cyc - m_start) == 35) && n < 500) begin
            step(1'b0, 8'h00, acc);
            n++;
        end
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        idle(3);
        send_byte(8'h81);
        wait_idle();
        idle(3);

        // all 256 byte values streamed through
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        wait_idle();
        idle(5);

        check("rx_count", rx_q.size(), m_sent.size());
        n = (rx_q.size() < m_sent.size()) ? rx_q.size() : m_sent.size();
        for (int i = 0; i < n; i++) begin
            check("rx_byte", {24'd0, rx_q[i]}, {24'd0, m_sent[i]});
        end
        check("rx_stop_err", rx_stop_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
